// File: rtl/mdu_core.sv
// Multiply/divide unit for the E stage: owns HI/LO and models multi-cycle latency.
// start/busy let the D-stage hazard logic stall md-class instructions.
module mdu_core #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDout
);

  localparam int unsigned W          = 32;
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]     hi_p_q, hi_p_d, lo_p_q, lo_p_d;

  logic             is_mul, is_div;
  logic [2*W-1:0]   mul_a, mul_b, prod;
  logic [W-1:0]     a_mag, b_mag, dividend, divisor, div_safe, q_u, r_u;
  logic [W-1:0]     res_hi, res_lo;

  assign is_mul = (MDop == OP_MULT) || (MDop == OP_MULTU);
  assign is_div = (MDop == OP_DIV)  || (MDop == OP_DIVU);
  assign busy   = (state_q == S_RUN);
  assign start  = (is_mul || is_div) && !req && !busy;
  assign HI     = hi_q;
  assign LO     = lo_q;

  // One multiplier and one magnitude divider shared by signed and unsigned ops.
  always_comb begin
    mul_a    = (MDop == OP_MULT) ? {{W{A[W-1]}}, A} : {{W{1'b0}}, A};
    mul_b    = (MDop == OP_MULT) ? {{W{B[W-1]}}, B} : {{W{1'b0}}, B};
    prod     = mul_a * mul_b;
    a_mag    = A[W-1] ? W'(-A) : A;
    b_mag    = B[W-1] ? W'(-B) : B;
    dividend = (MDop == OP_DIV) ? a_mag : A;
    divisor  = (MDop == OP_DIV) ? b_mag : B;
    div_safe = (divisor == '0) ? W'(1) : divisor;
    q_u      = dividend / div_safe;
    r_u      = dividend % div_safe;
    res_hi   = hi_q;
    res_lo   = lo_q;
    if (is_mul) begin
      res_hi = prod[2*W-1:W];
      res_lo = prod[W-1:0];
    end else if (is_div && (B != '0)) begin
      if (MDop == OP_DIV) begin
        res_lo = (A[W-1] ^ B[W-1]) ? W'(-q_u) : q_u;
        res_hi = A[W-1] ? W'(-r_u) : r_u;
      end else begin
        res_lo = q_u;
        res_hi = r_u;
      end
    end
  end

  // Next-state: accept, count down, commit pending result on the last busy edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_p_d  = hi_p_q;
    lo_p_d  = lo_p_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          hi_p_d  = res_hi;
          lo_p_d  = res_lo;
        end else if (!req && (MDop == OP_MTHI)) begin
          hi_d = A;
        end else if (!req && (MDop == OP_MTLO)) begin
          lo_d = A;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hi_d    = hi_p_q;
          lo_d    = lo_p_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_p_q  <= '0;
      lo_p_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_p_q  <= hi_p_d;
      lo_p_q  <= lo_p_d;
    end
  end

  always_comb begin
    MDout = '0;
    if (MDop == OP_MFHI) MDout = hi_q;
    else if (MDop == OP_MFLO) MDout = lo_q;
  end

endmodule
